valid_window_acc: RTL and testbench
===================================

# valid_window_acc

Parametrised windowed accumulator for valid-qualified sample streams. It watches `validi`/`data_in` and, once `N` consecutive valid samples have been taken, emits their sum with a one-cycle `valido` strobe. A `mode` input selects non-overlapping windows or a sliding window. The block generalises the fixed 32-bit, fixed-run valid checker used in the lab property exercises and is the DUT for the next assertion/bind exercise.

## Interface
- `DW`, 32, data input width in bits (≥ 1).
- `N`, 3, window length in samples (2..16).
- `OW`, `DW + $clog2(N)`, output width; derived, not overridden. It is wide enough that no sum can overflow.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `validi`  in  1  `data_in` is valid this cycle.
- `mode`  in  1  0 = block (non-overlapping windows), 1 = sliding window.
- `data_in`  in  `DW`  sample, unsigned.
- `valido`  out  1  one-cycle strobe: `data_out` carries a new window sum.
- `data_out`  out  `OW`  sum of the last `N` consecutive valid samples, unsigned.
- `run_len`  out  `$clog2(N+1)`  number of consecutive valid samples currently held, 0..`N`.

## Operation
- Internal state:
  - sample history `hist[0..N-1]`;
  - run counter `cnt` (0..`N`);
  - running sum `acc` (`OW` bits);
  - registered `mode_q`.
- The cycle is a run break when any of these holds: `validi` = 0, or `mode` ≠ `mode_q`.
- On a run break:
  - `cnt` ← 0 and `acc` ← 0;
  - if `validi` = 1 (mode change only), the current sample is accepted as the first sample of a new run: `cnt` ← 1, `acc` ← `data_in`;
  - `mode_q` ← `mode` in every cycle.
- Accept while `cnt` < `N`: shift `data_in` into `hist`, `cnt` += 1, `acc` += `data_in` (zero-extended).
- Emit when an accepted sample makes `cnt` reach `N`: next cycle `valido` = 1 and `data_out` = `acc` including that sample.
- After an emit with `mode_q` = 0 (block): `cnt` ← 0 and `acc` ← 0. The next valid sample starts a fresh window, so windows never overlap.
- After an emit with `mode_q` = 1 (sliding): `cnt` stays `N`.
  - Each further valid sample updates `acc` ← `acc` + `data_in` − `hist[oldest]` and shifts `hist`.
  - It emits again, so one sum is produced per valid cycle for as long as the run lasts.
- `data_out` holds its last emitted value while `valido` = 0; it changes only on an emit or a reset.
- `run_len` mirrors the registered `cnt`. In block mode it reads 0 in the cycle after an emit.
- All arithmetic is unsigned, with no saturation and no wrap within `OW`.

## Timing
- Reset (`rst` = 0 at a rising edge), taking priority over all other inputs:
  - `valido` = 0, `data_out` = 0, `run_len` = 0;
  - `acc` = 0, `hist` cleared, `mode_q` ← `mode`.
- Reset mid-run discards the partial window; no emit follows.
- Inputs are sampled on the rising edge.
- Latency: `valido` rises in the cycle after the edge that samples the `N`th consecutive valid sample.
- `valido` is high for exactly one cycle per emit. In sliding mode it stays high on consecutive cycles while valid samples keep arriving.
- Any emit is preceded by at least `N` consecutive valid cycles since the last reset, run break or block-mode emit.
- `validi` = 0 directly after an emit: no further emit; `data_out` is held.
- A mode change on the same cycle that would complete a window counts as a run break and produces no emit.

## Test plan
- Reset, then the lab-4 pattern with `N`=3, `mode`=0, and `data_in` incrementing from 2 each cycle:
  - `validi` = 0,1,0,1,1,0,0,1,1,1,0 → single `valido` pulse with `data_out` = 30 (9+10+11), one cycle after 11 is sampled;
  - `run_len` sequence 0,1,0,1,2,0,0,1,2,3→0,0.
- `N`=3, `mode`=0, six consecutive valid samples 1..6 → pulses with `data_out` = 6 and then 15; `run_len` returns to 0 after each.
- `N`=3, `mode`=1, the same six samples → four consecutive pulses with `data_out` = 6, 9, 12, 15; `valido` drops the cycle after `validi` falls.
- `DW`=32, `N`=3, three samples of 0xFFFF_FFFF → `data_out` = 0x2_FFFF_FFFD (34 bits), with no overflow.
- `rst` = 0 after two valid samples, then three more valid samples → exactly one pulse, with the sum of the three post-reset samples only; `data_out` reads 0 until that pulse.
- `N`=4, `mode` toggled 0→1 after two valid samples, with `validi` held high → run restarts at the toggle sample; first pulse carries the sum of that sample and the next three, then sliding pulses follow every cycle.

Source files
------------

// File: rtl/valid_window_acc_if.sv
// Sample-stream bundle for valid_window_acc: qualified input samples in,
// window sums and current run length out.
interface valid_window_acc_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned N  = 3
);
    localparam int unsigned OW = DW + $clog2(N);
    localparam int unsigned CW = $clog2(N + 1);

    logic          validi;
    logic          mode;
    logic [DW-1:0] data_in;
    logic          valido;
    logic [OW-1:0] data_out;
    logic [CW-1:0] run_len;

    modport master (
        output validi, mode, data_in,
        input  valido, data_out, run_len
    );

    modport slave (
        input  validi, mode, data_in,
        output valido, data_out, run_len
    );
endinterface

// File: rtl/valid_window_acc.sv
// Windowed accumulator: sums N consecutive valid samples and strobes valido
// with the sum. mode=0 gives non-overlapping windows, mode=1 a sliding window
// that emits once per valid sample after the first N.
module valid_window_acc #(
    parameter int unsigned DW = 32,
    parameter int unsigned N  = 3
) (
    input  logic              clk,
    input  logic              rst,
    valid_window_acc_if.slave bus
);
    localparam int unsigned OW = DW + $clog2(N);
    localparam int unsigned CW = $clog2(N + 1);

    logic [DW-1:0] hist_q [N];
    logic [DW-1:0] hist_d [N];
    logic [CW-1:0] cnt_q, cnt_d;
    logic [OW-1:0] acc_q, acc_d;
    logic [OW-1:0] data_out_q, data_out_d;
    logic          mode_q, mode_d;
    logic          valido_q, valido_d;
    logic          run_break;
    logic [OW-1:0] sum;

    // Next-state: run-break handling, window fill, emit and sliding update.
    always_comb begin
        hist_d     = hist_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mode_d     = bus.mode;
        valido_d   = 1'b0;
        data_out_d = data_out_q;
        sum        = '0;
        run_break  = !bus.validi || (bus.mode != mode_q);

        if (run_break) begin
            cnt_d = '0;
            acc_d = '0;
            // A mode change with valid data opens a new run on this sample.
            if (bus.validi) begin
                hist_d[0] = bus.data_in;
                for (int unsigned i = 1; i < N; i++) hist_d[i] = hist_q[i-1];
                cnt_d = CW'(1);
                acc_d = OW'(bus.data_in);
            end
        end else if (cnt_q < CW'(N)) begin
            hist_d[0] = bus.data_in;
            for (int unsigned i = 1; i < N; i++) hist_d[i] = hist_q[i-1];
            sum = acc_q + OW'(bus.data_in);
            if (cnt_q == CW'(N - 1)) begin
                valido_d   = 1'b1;
                data_out_d = sum;
                if (mode_q) begin
                    cnt_d = CW'(N);
                    acc_d = sum;
                end else begin
                    cnt_d = '0;
                    acc_d = '0;
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
                acc_d = sum;
            end
        end else begin
            // Full sliding window: drop the oldest sample, add the newest.
            // Intermediate wrap in OW bits cancels; the result is an N-sum.
            sum = acc_q + OW'(bus.data_in) - OW'(hist_q[N-1]);
            hist_d[0] = bus.data_in;
            for (int unsigned i = 1; i < N; i++) hist_d[i] = hist_q[i-1];
            acc_d      = sum;
            valido_d   = 1'b1;
            data_out_d = sum;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < N; i++) hist_q[i] <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            mode_q     <= bus.mode;
            valido_q   <= 1'b0;
            data_out_q <= '0;
        end else begin
            for (int unsigned i = 0; i < N; i++) hist_q[i] <= hist_d[i];
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mode_q     <= mode_d;
            valido_q   <= valido_d;
            data_out_q <= data_out_d;
        end
    end

    assign bus.valido   = valido_q;
    assign bus.data_out = data_out_q;
    assign bus.run_len  = cnt_q;
endmodule

// File: tb/tb_valid_window_acc.sv
// Bench for valid_window_acc: two instances (N=3 and N=4), directed stimulus,
// expected sums queued at issue time and checked by per-instance monitors.
module tb_valid_window_acc;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    typedef struct {
        logic [33:0] val;
        int          cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    valid_window_acc_if #(.DW(32), .N(3)) ifa ();
    valid_window_acc_if #(.DW(32), .N(4)) ifb ();

    valid_window_acc #(.DW(32), .N(3)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    valid_window_acc #(.DW(32), .N(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor for the N=3 instance.
    always @(negedge clk) begin
        if (ifa.valido === 1'b1) begin
            n_checks++;
            if (qa.size() == 0) begin
                n_fail++;
                $display("FAIL pulse_a: unexpected pulse data_out=%0h at cycle %0d, none expected", ifa.data_out, cyc);
            end else begin
                exp_t e;
                e = qa.pop_front();
                if (ifa.data_out !== e.val || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL pulse_a: data_out=%0h cycle=%0d, expected %0h at cycle %0d", ifa.data_out, cyc, e.val, e.cyc);
                end
            end
        end
    end

    // Monitor for the N=4 instance.
    always @(negedge clk) begin
        if (ifb.valido === 1'b1) begin
            n_checks++;
            if (qb.size() == 0) begin
                n_fail++;
                $display("FAIL pulse_b: unexpected pulse data_out=%0h at cycle %0d, none expected", ifb.data_out, cyc);
            end else begin
                exp_t e;
                e = qb.pop_front();
                if (ifb.data_out !== e.val || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL pulse_b: data_out=%0h cycle=%0d, expected %0h at cycle %0d", ifb.data_out, cyc, e.val, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic da(input logic v, input logic m, input logic [31:0] d);
        ifa.validi  = v;
        ifa.mode    = m;
        ifa.data_in = d;
    endtask

    task automatic db(input logic v, input logic m, input logic [31:0] d);
        ifb.validi  = v;
        ifb.mode    = m;
        ifb.data_in = d;
    endtask

    task automatic pusha(input logic [33:0] v);
        qa.push_back(exp_t'{val: v, cyc: cyc + 1});
    endtask

    task automatic pushb(input logic [33:0] v);
        qb.push_back(exp_t'{val: v, cyc: cyc + 1});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int lab_v  [11] = '{0, 1, 0, 1, 1, 0, 0, 1, 1, 1, 0};
        int lab_rl [11] = '{0, 1, 0, 1, 2, 0, 0, 1, 2, 0, 0};
        int b_v    [9]  = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
        int b_m    [9]  = '{0, 0, 1, 1, 1, 1, 1, 1, 1};
        int b_d    [9]  = '{10, 20, 30, 40, 50, 60, 70, 80, 0};
        int b_rl   [9]  = '{1, 2, 1, 2, 3, 4, 4, 4, 0};

        da(0, 0, 0);
        db(0, 0, 0);
        rst = 1'b0;
        tick();
        tick();
        chk("reset_valido_a",   64'(ifa.valido),   0);
        chk("reset_data_out_a", 64'(ifa.data_out), 0);
        chk("reset_run_len_a",  64'(ifa.run_len),  0);
        chk("reset_valido_b",   64'(ifb.valido),   0);
        chk("reset_data_out_b", 64'(ifb.data_out), 0);
        chk("reset_run_len_b",  64'(ifb.run_len),  0);
        rst = 1'b1;

        // Lab pattern, block mode, data incrementing from 2.
        for (int i = 0; i < 11; i++) begin
            da(lab_v[i][0], 0, 32'(2 + i));
            if (i == 9) pusha(34'd30);
            tick();
            chk($sformatf("lab_run_len_%0d", i), 64'(ifa.run_len), 64'(lab_rl[i]));
        end
        chk("lab_valido_low", 64'(ifa.valido), 0);
        chk("lab_data_out_held", 64'(ifa.data_out), 30);

        // Block mode, six samples 1..6.
        for (int i = 0; i < 6; i++) begin
            da(1, 0, 32'(i + 1));
            if (i == 2) pusha(34'd6);
            if (i == 5) pusha(34'd15);
            tick();
            chk($sformatf("block_run_len_%0d", i), 64'(ifa.run_len), (i % 3 == 2) ? 64'd0 : 64'((i % 3) + 1));
        end
        da(0, 0, 0);
        tick();
        chk("block_run_len_idle", 64'(ifa.run_len), 0);

        // Sliding mode, six samples 1..6.
        da(0, 1, 0);
        tick();
        for (int i = 0; i < 6; i++) begin
            da(1, 1, 32'(i + 1));
            if (i >= 2) pusha(34'(3 * i));
            tick();
            chk($sformatf("slide_run_len_%0d", i), 64'(ifa.run_len), (i >= 2) ? 64'd3 : 64'(i + 1));
        end
        da(0, 1, 0);
        tick();
        chk("slide_valido_drop", 64'(ifa.valido), 0);
        chk("slide_run_len_drop", 64'(ifa.run_len), 0);
        chk("slide_data_out_held", 64'(ifa.data_out), 15);

        // Maximum samples: no overflow in 34 bits.
        da(0, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            da(1, 0, 32'hFFFF_FFFF);
            if (i == 2) pusha(34'h2_FFFF_FFFD);
            tick();
        end
        da(0, 0, 0);
        tick();
        chk("max_data_out", 64'(ifa.data_out), 64'h2_FFFF_FFFD);

        // Reset mid-run discards the partial window.
        da(1, 0, 100);
        tick();
        da(1, 0, 200);
        tick();
        rst = 1'b0;
        da(1, 0, 300);
        tick();
        chk("midrst_valido",   64'(ifa.valido),   0);
        chk("midrst_data_out", 64'(ifa.data_out), 0);
        chk("midrst_run_len",  64'(ifa.run_len),  0);
        rst = 1'b1;
        da(1, 0, 7);
        tick();
        chk("postrst_data_out_1", 64'(ifa.data_out), 0);
        chk("postrst_run_len_1",  64'(ifa.run_len),  1);
        da(1, 0, 8);
        tick();
        chk("postrst_data_out_2", 64'(ifa.data_out), 0);
        da(1, 0, 9);
        pusha(34'd24);
        tick();
        chk("postrst_run_len_3", 64'(ifa.run_len), 0);
        da(0, 0, 0);
        tick();

        // Mode change on the completing sample: run break, no emit.
        da(1, 0, 1);
        tick();
        da(1, 0, 2);
        tick();
        da(1, 1, 3);
        tick();
        chk("modechg_valido",  64'(ifa.valido),  0);
        chk("modechg_run_len", 64'(ifa.run_len), 1);
        da(0, 1, 0);
        tick();
        chk("modechg_run_len_idle", 64'(ifa.run_len), 0);
        chk("modechg_data_out_held", 64'(ifa.data_out), 24);

        // N=4: mode toggles after two samples, validi held high.
        for (int i = 0; i < 9; i++) begin
            db(b_v[i][0], b_m[i][0], 32'(b_d[i]));
            if (i == 5) pushb(34'd180);
            if (i == 6) pushb(34'd220);
            if (i == 7) pushb(34'd260);
            tick();
            chk($sformatf("toggle_run_len_%0d", i), 64'(ifb.run_len), 64'(b_rl[i]));
        end
        chk("toggle_valido_drop", 64'(ifb.valido), 0);

        tick();
        tick();
        chk("queue_a_drained", 64'(qa.size()), 0);
        chk("queue_b_drained", 64'(qb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
